// File: rtl/bitty_pkg.sv
// bitty_pkg: shared types and constants for the bitty fetch stage
package bitty_pkg;

    localparam int INSTR_W = 16;
    localparam logic [INSTR_W-1:0] HALT_WORD = 16'hFFFF;

    typedef enum logic [2:0] {IDLE, REQ, CAPT, EXEC, HALT} state_t;

endpackage

// File: rtl/bitty_fetch.sv
// bitty_fetch: PC, synchronous-read fetch and run/done dispatch to the core; BITTY_FETCH_HALT_EN adds the halt word
module bitty_fetch
    import bitty_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter logic [ADDR_W-1:0] LAST_ADDR = '1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_rd_en,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instruction,
    output logic               run,
    input  logic               done,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic [15:0]        retired,
    output logic               halted
);

    state_t state, state_n;

    assign run       = (state == EXEC) && !done;
    assign mem_rd_en = (state == REQ);
    assign mem_addr  = pc;

    // next-state decode
    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = start ? REQ : IDLE;
            REQ:  state_n = CAPT;
`ifdef BITTY_FETCH_HALT_EN
            CAPT: state_n = (mem_rdata == HALT_WORD) ? HALT : EXEC;
`else
            CAPT: state_n = EXEC;
`endif
            EXEC: state_n = !done ? EXEC : (pc == LAST_ADDR) ? IDLE : REQ;
            default: state_n = state;
        endcase
    end

    // state, program counter, instruction latch and retire counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= '0;
            instruction <= '0;
            retired     <= '0;
            busy        <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= (state_n != IDLE);
            if (state == IDLE && start) begin
                pc      <= '0;
                retired <= '0;
            end
            if (state == CAPT && state_n == EXEC)
                instruction <= mem_rdata;
            if (state == EXEC && done) begin
                retired <= (retired == 16'hFFFF) ? retired : retired + 16'd1;
                if (pc != LAST_ADDR)
                    pc <= pc + 1'b1;
            end
        end
    end

`ifdef BITTY_FETCH_HALT_EN
    // sticky halt flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset)
            halted <= 1'b0;
        else
            halted <= (state_n == HALT);
    end
`else
    assign halted = 1'b0;
`endif

endmodule

// File: doc/bitty_fetch.md
# bitty_fetch

Instruction fetch and dispatch stage directly upstream of the bitty execution core. Holds the program counter and reads 16-bit instruction words from a synchronous-read instruction memory. Presents each word to the core with `run` held high, waits for the core's `done` pulse, then advances to the next address. Runs a program from address 0 through `LAST_ADDR` once per `start`.

## Interface
- `ADDR_W`, default 8: instruction memory address width.
- `LAST_ADDR`, default 2**ADDR_W-1: address of the final instruction in the program.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high; sampled on the rising edge of `clk`.
- `start`  in  1: one-cycle request to begin a program run from address 0.
- `mem_addr`  out  ADDR_W: instruction memory read address.
- `mem_rd_en`  out  1: memory read strobe.
- `mem_rdata`  in  16: memory read data, valid one cycle after the `mem_rd_en` cycle.
- `instruction`  out  16: registered instruction word presented to the core.
- `run`  out  1: execute request to the core.
- `done`  in  1: one-cycle completion pulse from the core.
- `pc`  out  ADDR_W: current program counter.
- `busy`  out  1: high in every state except IDLE.
- `retired`  out  16: count of completed instructions; saturates at 16'hFFFF.
- `halted`  out  1: a halt word was fetched (only when `BITTY_FETCH_HALT_EN` is defined, see Configuration).

## Operation
- State machine: IDLE, REQ, CAPT, EXEC, and HALT (HALT exists only when `BITTY_FETCH_HALT_EN` is defined).
- IDLE, `start`=1: `pc`<=0, `retired`<=0, go to REQ.
- IDLE, `start`=0: stay in IDLE.
- REQ: `mem_rd_en`=1 and `mem_addr`=`pc` combinationally. Go to CAPT.
- CAPT: `instruction`<=`mem_rdata`, go to EXEC.
- EXEC: `run` = (state==EXEC) && !`done`. This is combinational, so `run` drops in the same cycle `done` is seen and the core cannot re-enter its first step.
- EXEC, `done`=1:
  - `retired`<=`retired`+1, saturating.
  - If `pc`==`LAST_ADDR`: go to IDLE; `pc` holds its value.
  - Otherwise: `pc`<=`pc`+1, go to REQ.
- `pc` arithmetic is modulo 2**ADDR_W. No wrap occurs in practice, because a run ends at `LAST_ADDR`.
- `instruction` holds its value from CAPT until the next CAPT, so the core sees a stable word for its whole execution.
- `start` while `busy`: ignored.
- `done` outside EXEC: ignored; no state change.
- Reset values:
  - state=IDLE
  - `pc`=0, `instruction`=0, `retired`=0
  - `run`=0, `mem_rd_en`=0, `busy`=0, `halted`=0
- Reset mid-operation: aborts immediately to the values above. Reset wins over a simultaneous `start` or `done`.

## Timing
- `start` at edge N: REQ during cycle N+1, CAPT during N+2, EXEC with `run`=1 from N+3.
- Fetch overhead is 3 cycles per instruction (REQ, CAPT, and the `done` cycle), in addition to the core's execution time.
- The next REQ follows the `done` cycle immediately.
- All outputs are registered except `run`, `mem_rd_en` and `mem_addr`, which are decoded from state and registers with no input-to-output path other than `done`→`run`.

## Configuration
- `BITTY_FETCH_HALT_EN` defined:
  - In CAPT, a word equal to `HALT_WORD` (16'hFFFF) is not dispatched.
  - FSM goes to HALT: `halted`=1, `busy`=1, `run`=0.
  - HALT is left only by `reset`; `start` is ignored there.
  - `retired` does not count the halt word.
- `BITTY_FETCH_HALT_EN` undefined:
  - No HALT state; `halted` is tied to 0.
  - 16'hFFFF is dispatched like any other word.

## Structure
- Shared package `bitty_pkg` holds:
  - the state enum (IDLE, REQ, CAPT, EXEC, HALT)
  - `HALT_WORD`
  - the instruction width constant (16)
- No sub-module: a single FSM plus registers. The instruction memory is external and instantiated by the top level beside the core.

## Test plan
- Reset, then `start` with memory words 0x0004/0x2008/0x4010 at addresses 0–2, `LAST_ADDR`=2, core model pulses `done` 3 cycles after `run` rises -> the three words are presented in order; `retired`=3; `busy` falls; `pc`=2.
- `run` timing -> `run` is high for exactly the cycles before `done` and low in the `done` cycle; `instruction` is stable throughout EXEC.
- `start` pulsed during EXEC, and `done` pulsed during REQ -> no effect on `pc`, state, or `retired`.
- `reset` asserted in EXEC at `pc`=5 -> next cycle: `pc`=0, `run`=0, `busy`=0, `instruction`=0.
- With `BITTY_FETCH_HALT_EN`, word 0xFFFF at address 1 -> address 0 retires; `halted`=1; `run` is never raised for the halt word; `start` is ignored until `reset`.
- Without `BITTY_FETCH_HALT_EN`, the same program -> 0xFFFF is dispatched with `run`=1; `halted` stays 0.
